acia_tx_fifo: RTL and testbench
===============================

// Module: acia_tx_fifo
// PURPOSE
//   Parametrised successor of the ACIA serial transmitter. Buffers bytes in an
//   internal FIFO and sends frames with run-time selectable data length (5-8),
//   parity (none/even/odd) and stop bits (1/2). Sits between the CPU-side ACIA
//   register interface and the tx pin. Bit timing uses the pclk enable.
// PARAMETERS
//   SCW      9    width of the symbol-rate counter
//   sym_cnt  417  counter reload; bit period = (sym_cnt+1) pclk-enabled cycles
//   AW       3    FIFO address width; depth = 2**AW entries
// PORTS
//   clk         in   1     system clock, all logic on posedge
//   reset       in   1     asynchronous, active-high reset
//   pclk        in   1     peripheral clock enable; bit timing advances only when 1
//   tx_dat      in   8     byte to enqueue; only bits [N-1:0] are sent
//   tx_we       in   1     push tx_dat into FIFO (one push per clk cycle when high)
//   cfg_bits    in   2     data length N: 00=5, 01=6, 10=7, 11=8
//   cfg_par     in   2     0x=none, 10=even, 11=odd
//   cfg_stop    in   1     0=one stop bit, 1=two stop bits
//   tx_serial   out  1     serial output, idle high
//   tx_busy     out  1     a frame is in progress (state != IDLE)
//   fifo_empty  out  1     FIFO holds 0 entries
//   fifo_full   out  1     FIFO holds 2**AW entries
//   fifo_cnt    out  AW+1  current FIFO occupancy
//   tx_ovr      out  1     sticky: push attempted while full
// BEHAVIOUR
//   Reset (async): tx_serial=1, tx_busy=0, fifo_empty=1, fifo_full=0,
//     fifo_cnt=0, tx_ovr=0, state=IDLE, counters 0, FIFO pointers 0.
//     Reset mid-frame aborts: line returns high immediately, FIFO contents lost.
//   FIFO: push on any clk edge with tx_we=1 and fifo_full=0 (not gated by pclk).
//     Push while full is dropped and sets tx_ovr; tx_ovr clears only on reset.
//     Push when full is dropped even if a pop occurs in the same cycle.
//     Push and pop in the same cycle (not full): fifo_cnt unchanged.
//     Pointers wrap modulo 2**AW; fifo_cnt/flags registered, updated same edge.
//   All state-machine actions below occur only on clk edges with pclk=1.
//   States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//   IDLE: tx_serial=1. If fifo_empty=0: pop head, latch N, parity mode and stop
//     count into frame registers, tx_serial<=0, rcnt<=sym_cnt, go START.
//     A byte pushed on this same edge is not eligible until the next pclk.
//   Bit timing: rcnt decrements each pclk; at rcnt==0 advance to next bit and
//     reload sym_cnt, so every bit lasts exactly sym_cnt+1 pclk cycles.
//   START -> DATA: send data LSB first, N bits.
//   DATA -> PARITY if parity enabled, else STOP. Parity bit = XOR of the N sent
//     bits (even), inverted for odd. Bits above N-1 never affect parity.
//   STOP: tx_serial=1 for 1 or 2 bit periods, then IDLE.
//   At the final STOP rcnt==0 edge: if FIFO is non-empty, pop and enter START
//     directly (back-to-back, no idle gap); else go IDLE.
//   cfg_* changes mid-frame do not affect the frame in progress.
//   Frame length = 1+N+P+S bits; frame-start-to-frame-start = that x(sym_cnt+1).
// TESTING (sym_cnt=3, pclk tied 1, AW=3 unless stated)
//   Reset: outputs match reset values; assert reset mid-frame -> tx_serial=1
//     in the same cycle, fifo_cnt=0.
//   8N1: push 8'hA5 -> line 0,1,0,1,0,0,1,0,1,1, each bit 4 clk; tx_busy low
//     after 40 clk.
//   7E2: push 8'hFF, cfg 10/10/1 -> 0,1111111,1(even),1,1; bit 7 ignored.
//     5O1 with 8'h03 -> data 11000, parity 1.
//   Back-to-back: push 3 bytes in one burst -> 3 frames, no idle gap,
//     fifo_cnt 3->0.
//   Full/overrun: hold line busy, push 9 bytes -> fifo_full=1 after 8,
//     9th dropped, tx_ovr=1; all 8 sent in order.
//   pclk=1 every 3rd clk -> each bit lasts 12 clk; cfg change mid-frame has
//     no effect on the current frame.

Source files
------------

// File: rtl/acia_tx_fifo.sv
// ACIA serial transmitter with an input byte FIFO and run-time frame format
// (5-8 data bits, none/even/odd parity, 1 or 2 stop bits). Bit timing follows pclk.
module acia_tx_fifo #(
   parameter int SCW     = 9,
   parameter int sym_cnt = 417,
   parameter int AW      = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          pclk,
   input  logic [7:0]    tx_dat,
   input  logic          tx_we,
   input  logic [1:0]    cfg_bits,
   input  logic [1:0]    cfg_par,
   input  logic          cfg_stop,
   output logic          tx_serial,
   output logic          tx_busy,
   output logic          fifo_empty,
   output logic          fifo_full,
   output logic [AW:0]   fifo_cnt,
   output logic          tx_ovr
);

   localparam int DEPTH = 2**AW;
   localparam logic [SCW-1:0] RELOAD = SCW'(sym_cnt);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t          state, state_nx;
   logic [7:0]      mem [DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [AW:0]     cnt_nx;
   logic            push, pop, load;

   logic [SCW-1:0]  rcnt, rcnt_nx;
   logic [7:0]      shreg, shreg_nx;
   logic [2:0]      bit_idx, bit_idx_nx;
   logic [2:0]      last_idx, last_idx_nx;
   logic            par_en, par_en_nx;
   logic            par_odd, par_odd_nx;
   logic            two_stop, two_stop_nx;
   logic            stop_idx, stop_idx_nx;
   logic            par_acc, par_acc_nx;
   logic            txd_nx;

   // FIFO: pushes ignore pclk; a push while full is dropped even if a pop
   // frees a slot on the same edge.
   assign push   = tx_we && !fifo_full;
   assign cnt_nx = fifo_cnt + (AW+1)'(push) - (AW+1)'(pop);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_cnt   <= '0;
         fifo_empty <= 1'b1;
         fifo_full  <= 1'b0;
         tx_ovr     <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (tx_we && fifo_full)
            tx_ovr <= 1'b1;
         fifo_cnt   <= cnt_nx;
         fifo_empty <= (cnt_nx == '0);
         fifo_full  <= (cnt_nx == (AW+1)'(DEPTH));
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= tx_dat;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         rcnt      <= '0;
         shreg     <= '0;
         bit_idx   <= '0;
         last_idx  <= '0;
         par_en    <= 1'b0;
         par_odd   <= 1'b0;
         two_stop  <= 1'b0;
         stop_idx  <= 1'b0;
         par_acc   <= 1'b0;
         tx_serial <= 1'b1;
      end else begin
         state     <= state_nx;
         rcnt      <= rcnt_nx;
         shreg     <= shreg_nx;
         bit_idx   <= bit_idx_nx;
         last_idx  <= last_idx_nx;
         par_en    <= par_en_nx;
         par_odd   <= par_odd_nx;
         two_stop  <= two_stop_nx;
         stop_idx  <= stop_idx_nx;
         par_acc   <= par_acc_nx;
         tx_serial <= txd_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      rcnt_nx     = rcnt;
      shreg_nx    = shreg;
      bit_idx_nx  = bit_idx;
      last_idx_nx = last_idx;
      par_en_nx   = par_en;
      par_odd_nx  = par_odd;
      two_stop_nx = two_stop;
      stop_idx_nx = stop_idx;
      par_acc_nx  = par_acc;
      txd_nx      = tx_serial;
      load        = 1'b0;
      pop         = 1'b0;

      if (pclk) begin
         if (state != IDLE && rcnt != '0)
            rcnt_nx = rcnt - SCW'(1);

         case (state)
            IDLE: begin
               txd_nx = 1'b1;
               if (!fifo_empty)
                  load = 1'b1;
            end
            START: begin
               if (rcnt == '0) begin
                  state_nx   = DATA;
                  rcnt_nx    = RELOAD;
                  bit_idx_nx = '0;
                  txd_nx     = shreg[0];
                  par_acc_nx = shreg[0];
               end
            end
            DATA: begin
               if (rcnt == '0) begin
                  rcnt_nx = RELOAD;
                  if (bit_idx == last_idx) begin
                     if (par_en) begin
                        state_nx = PARITY;
                        txd_nx   = par_acc ^ par_odd;
                     end else begin
                        state_nx    = STOP;
                        stop_idx_nx = 1'b0;
                        txd_nx      = 1'b1;
                     end
                  end else begin
                     bit_idx_nx = bit_idx + 3'd1;
                     shreg_nx   = {1'b0, shreg[7:1]};
                     txd_nx     = shreg[1];
                     par_acc_nx = par_acc ^ shreg[1];
                  end
               end
            end
            PARITY: begin
               if (rcnt == '0) begin
                  state_nx    = STOP;
                  rcnt_nx     = RELOAD;
                  stop_idx_nx = 1'b0;
                  txd_nx      = 1'b1;
               end
            end
            STOP: begin
               if (rcnt == '0) begin
                  rcnt_nx = RELOAD;
                  if (two_stop && !stop_idx) begin
                     stop_idx_nx = 1'b1;
                  end else if (!fifo_empty) begin
                     load = 1'b1;
                  end else begin
                     state_nx = IDLE;
                     txd_nx   = 1'b1;
                  end
               end
            end
            default: state_nx = IDLE;
         endcase

         // Shared frame start for IDLE and back-to-back entry from STOP;
         // the frame format is captured here so later cfg changes are ignored.
         if (load) begin
            pop         = 1'b1;
            state_nx    = START;
            rcnt_nx     = RELOAD;
            shreg_nx    = mem[rd_ptr];
            last_idx_nx = {1'b1, cfg_bits};
            par_en_nx   = cfg_par[1];
            par_odd_nx  = cfg_par[0];
            two_stop_nx = cfg_stop;
            stop_idx_nx = 1'b0;
            txd_nx      = 1'b0;
         end
      end
   end

   assign tx_busy = (state != IDLE);

endmodule

// File: tb/tb_acia_tx_fifo.sv
// Scoreboard bench for acia_tx_fifo: stimulus queues expected serial frames,
// a monitor decodes the line and compares them.
module tb_acia_tx_fifo;

   logic        clk = 1'b0;
   logic        reset;
   logic        pclk;
   logic [7:0]  tx_dat;
   logic        tx_we;
   logic [1:0]  cfg_bits;
   logic [1:0]  cfg_par;
   logic        cfg_stop;
   logic        tx_serial;
   logic        tx_busy;
   logic        fifo_empty;
   logic        fifo_full;
   logic [3:0]  fifo_cnt;
   logic        tx_ovr;

   int pclk_mode = 1;
   int div = 0;
   int cyc = 0;
   int checks = 0;
   int errors = 0;
   logic mon_en = 1'b0;
   logic mon_busy = 1'b0;

   typedef struct {
      logic [15:0] bits;
      int          len;
      int          p;
      int          gap;
   } frame_t;

   frame_t exp_q[$];

   acia_tx_fifo #(.SCW(9), .sym_cnt(3), .AW(3)) dut (
      .clk(clk), .reset(reset), .pclk(pclk),
      .tx_dat(tx_dat), .tx_we(tx_we),
      .cfg_bits(cfg_bits), .cfg_par(cfg_par), .cfg_stop(cfg_stop),
      .tx_serial(tx_serial), .tx_busy(tx_busy),
      .fifo_empty(fifo_empty), .fifo_full(fifo_full),
      .fifo_cnt(fifo_cnt), .tx_ovr(tx_ovr)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      div <= (div == 2) ? 0 : div + 1;
      cyc <= cyc + 1;
   end

   // pclk: 0 = held low, 1 = tied high, 3 = high every third clk
   assign pclk = (pclk_mode == 1) || (pclk_mode == 3 && div == 0);

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic expect_frame(input logic [15:0] bits, input int len, input int p, input int gap);
      frame_t f;
      f.bits = bits;
      f.len  = len;
      f.p    = p;
      f.gap  = gap;
      exp_q.push_back(f);
   endtask

   task automatic push_byte(input logic [7:0] d);
      @(negedge clk);
      tx_dat = d;
      tx_we  = 1'b1;
      @(negedge clk);
      tx_we  = 1'b0;
   endtask

   task automatic drain(input string name);
      int k = 0;
      while ((exp_q.size() != 0 || mon_busy || tx_busy) && k < 3000) begin
         @(negedge clk);
         k++;
      end
      checks++;
      if (k >= 3000) begin
         errors++;
         $display("FAIL %s_timeout actual=%0d pending frames required=0", name, exp_q.size());
      end
   endtask

   // Monitor: start bit detected on a negedge, then each bit sampled mid-period.
   initial begin
      frame_t e;
      logic [15:0] got;
      int start_cyc;
      int last_start = 0;
      forever begin
         @(negedge clk);
         if (mon_en && tx_serial === 1'b0) begin
            mon_busy = 1'b1;
            start_cyc = cyc;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_frame actual=start_bit required=idle_line");
               for (int k = 0; k < 200 && tx_serial === 1'b0; k++)
                  @(negedge clk);
            end else begin
               e = exp_q.pop_front();
               if (e.gap != 0)
                  chk("frame_gap", 16'(start_cyc - last_start), 16'(e.gap));
               last_start = start_cyc;
               got = '0;
               repeat (e.p / 2) @(negedge clk);
               got = {got[14:0], tx_serial};
               for (int i = 1; i < e.len; i++) begin
                  repeat (e.p) @(negedge clk);
                  got = {got[14:0], tx_serial};
               end
               chk("frame_bits", got, e.bits);
            end
            mon_busy = 1'b0;
         end
      end
   end

   initial begin
      int n;
      int k;
      reset    = 1'b1;
      tx_we    = 1'b0;
      tx_dat   = 8'h00;
      cfg_bits = 2'b11;
      cfg_par  = 2'b00;
      cfg_stop = 1'b0;
      repeat (3) @(negedge clk);

      chk("rst_serial", 16'(tx_serial), 16'd1);
      chk("rst_busy",   16'(tx_busy),   16'd0);
      chk("rst_empty",  16'(fifo_empty), 16'd1);
      chk("rst_full",   16'(fifo_full), 16'd0);
      chk("rst_cnt",    16'(fifo_cnt),  16'd0);
      chk("rst_ovr",    16'(tx_ovr),    16'd0);
      reset = 1'b0;

      // abort a frame in progress with a second byte queued
      @(negedge clk);
      tx_dat = 8'h00; tx_we = 1'b1;
      @(negedge clk);
      tx_dat = 8'h55;
      @(negedge clk);
      tx_we = 1'b0;
      repeat (8) @(negedge clk);
      chk("mid_busy", 16'(tx_busy),   16'd1);
      chk("mid_line", 16'(tx_serial), 16'd0);
      chk("mid_cnt",  16'(fifo_cnt),  16'd1);
      reset = 1'b1;
      #1;
      chk("abort_line",  16'(tx_serial),  16'd1);
      chk("abort_cnt",   16'(fifo_cnt),   16'd0);
      chk("abort_busy",  16'(tx_busy),    16'd0);
      chk("abort_empty", 16'(fifo_empty), 16'd1);
      @(negedge clk);
      reset  = 1'b0;
      mon_en = 1'b1;

      // 8N1, 0xA5, busy for 10 bits x 4 clk
      expect_frame(16'b0101001011, 10, 4, 0);
      push_byte(8'hA5);
      k = 0;
      while (!tx_busy && k < 20) begin @(negedge clk); k++; end
      n = 0;
      while (tx_busy && n < 200) begin @(negedge clk); n++; end
      chk("busy_len_8n1", 16'(n), 16'd40);
      drain("8n1");

      // 7E2, 0xFF: bit 7 not sent and not in parity
      cfg_bits = 2'b10; cfg_par = 2'b10; cfg_stop = 1'b1;
      expect_frame(16'b01111111111, 11, 4, 0);
      push_byte(8'hFF);
      drain("7e2");

      // 5O1, 0xE3: upper bits must not leak into data or parity
      cfg_bits = 2'b00; cfg_par = 2'b11; cfg_stop = 1'b0;
      expect_frame(16'b01100011, 8, 4, 0);
      push_byte(8'hE3);
      drain("5o1");

      // back-to-back: three bytes queued while the state machine is stalled
      cfg_bits = 2'b11; cfg_par = 2'b00; cfg_stop = 1'b0;
      pclk_mode = 0;
      expect_frame(16'b0001111001, 10, 4, 0);
      expect_frame(16'b0110000111, 10, 4, 40);
      expect_frame(16'b0100000011, 10, 4, 40);
      @(negedge clk); tx_dat = 8'h3C; tx_we = 1'b1;
      @(negedge clk); tx_dat = 8'hC3;
      @(negedge clk); tx_dat = 8'h81;
      @(negedge clk); tx_we = 1'b0;
      chk("b2b_cnt3",  16'(fifo_cnt),   16'd3);
      chk("b2b_empty", 16'(fifo_empty), 16'd0);
      pclk_mode = 1;
      drain("b2b");
      chk("b2b_cnt0",   16'(fifo_cnt),   16'd0);
      chk("b2b_empty1", 16'(fifo_empty), 16'd1);

      // fill to full, then push on the same edge as the first pop
      pclk_mode = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         tx_dat = 8'(1 << i);
         tx_we  = 1'b1;
      end
      @(negedge clk);
      tx_we = 1'b0;
      expect_frame(16'b0100000001, 10, 4, 0);
      expect_frame(16'b0010000001, 10, 4, 40);
      expect_frame(16'b0001000001, 10, 4, 40);
      expect_frame(16'b0000100001, 10, 4, 40);
      expect_frame(16'b0000010001, 10, 4, 40);
      expect_frame(16'b0000001001, 10, 4, 40);
      expect_frame(16'b0000000101, 10, 4, 40);
      expect_frame(16'b0000000011, 10, 4, 40);
      chk("full_flag", 16'(fifo_full), 16'd1);
      chk("full_cnt",  16'(fifo_cnt),  16'd8);
      chk("full_ovr0", 16'(tx_ovr),    16'd0);
      @(negedge clk);
      pclk_mode = 1;
      tx_dat = 8'hEE;
      tx_we  = 1'b1;
      @(negedge clk);
      tx_we = 1'b0;
      chk("ovr_set",   16'(tx_ovr),    16'd1);
      chk("ovr_cnt",   16'(fifo_cnt),  16'd7);
      chk("ovr_full0", 16'(fifo_full), 16'd0);
      drain("full");
      chk("ovr_sticky", 16'(tx_ovr),     16'd1);
      chk("full_empty", 16'(fifo_empty), 16'd1);

      // slow pclk (every 3rd clk) with a cfg change mid-frame
      pclk_mode = 3;
      expect_frame(16'b0010110101, 10, 12, 0);
      push_byte(8'h5A);
      k = 0;
      while (!tx_busy && k < 20) begin @(negedge clk); k++; end
      repeat (30) @(negedge clk);
      cfg_bits = 2'b00; cfg_par = 2'b11; cfg_stop = 1'b1;
      drain("slow");
      chk("slow_idle", 16'(tx_serial), 16'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
